// File: rtl/uart_tx_fifo_drain_if.sv
// Read port of the first-word fall-through FIFO as seen by the UART drain stage.
// The master side is the drain logic. It watches empty/data and pulses read.
interface uart_tx_fifo_drain_if #(
  parameter int DATA_SIZE = 8
);
  logic                 fifo_empty;
  logic [DATA_SIZE-1:0] fifo_data;
  logic                 fifo_read;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_read
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_read
  );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// uart_tx_fifo_drain: drains a FWFT FIFO one word at a time and shifts each word
// out as an 8N1 UART frame (start bit, DATA_SIZE data bits LSB first, stop bit).
// The word is latched on the same edge that schedules the pop, so a
// one-cycle empty-flag latency inside the FIFO can never cause a double read.
// When another word is ready at the end of a stop bit, the next frame starts
// on that same edge, so back-to-back frames have no idle gap.
module uart_tx_fifo_drain #(
  parameter int DATA_SIZE    = 8,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tx_enable,
  uart_tx_fifo_drain_if.master fifo,
  output logic                tx,
  output logic                tx_busy,
  output logic                tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_SIZE);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_SIZE - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]           state;
  logic [CW-1:0]        baud_cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_SIZE-1:0] shift_reg;
  logic                 bit_end;
  logic                 start_ok;

  assign bit_end  = (baud_cnt == CNT_LAST);
  assign start_ok = tx_enable && !fifo.fifo_empty;

  // Baud counter: held at zero while idle, otherwise counts one bit period and wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
    end else if (state == IDLE || bit_end) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

  // Frame sequencer: latch word and pop FIFO, then walk start/data/stop bits on bit_end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      tx             <= 1'b1;
      tx_busy        <= 1'b0;
      tx_done        <= 1'b0;
      fifo.fifo_read <= 1'b0;
      bit_idx        <= '0;
      shift_reg      <= '0;
    end else begin
      fifo.fifo_read <= 1'b0;
      tx_done        <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start_ok) begin
            shift_reg      <= fifo.fifo_data;
            fifo.fifo_read <= 1'b1;
            tx             <= 1'b0;
            tx_busy        <= 1'b1;
            state          <= START;
          end
        end
        START: begin
          if (bit_end) begin
            tx      <= shift_reg[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == IDX_LAST) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
              bit_idx   <= bit_idx + IW'(1);
            end
          end
        end
        STOP: begin
          if (bit_end) begin
            tx_done <= 1'b1;
            if (start_ok) begin
              shift_reg      <= fifo.fifo_data;
              fifo.fifo_read <= 1'b1;
              tx             <= 1'b0;
              state          <= START;
            end else begin
              tx      <= 1'b1;
              tx_busy <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// tb_uart_tx_fifo_drain: drives uart_tx_fifo_drain from a queue-based FWFT FIFO
// model and decodes the serial line back into bytes. Every written byte is
// pushed to an expected queue. A line monitor pops from that queue and compares
// each decoded frame against it.
module tb_uart_tx_fifo_drain;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int FRAME = (DW + 2) * CPB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_enable = 1'b0;
  logic tx;
  logic tx_busy;
  logic tx_done;

  uart_tx_fifo_drain_if #(.DATA_SIZE(DW)) fifo_if ();

  uart_tx_fifo_drain #(
    .DATA_SIZE   (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_enable(tx_enable),
    .fifo     (fifo_if),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int pop_count = 0;
  int underflow = 0;
  int words_written = 0;
  int frames_ok = 0;
  int done_pulses = 0;
  int max_occ = 0;
  int frame_start_cyc[$];
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] wr_pend[$];
  logic [DW-1:0] exp_q[$];
  logic prev_rd = 1'b0;

  logic [9:0] mon_bits;
  int mon_bad;
  bit mon_abort;
  bit mon_chain;

  // Free-running clock
  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] b);
    wr_pend.push_back(b);
    exp_q.push_back(b);
    words_written++;
  endtask

  task automatic waitDrain(input int budget, input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || wr_pend.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic waitFrameStart(input int budget, input string tag);
    int n = 0;
    int n0 = frame_start_cyc.size();
    while (frame_start_cyc.size() == n0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, (frame_start_cyc.size() > n0), 1);
  endtask

  // FIFO pop side: the strobe seen during the previous cycle removes the head word
  always @(posedge clk) begin
    cyc++;
    if (fifo_if.fifo_read === 1'b1) begin
      pop_count++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      else underflow++;
    end
  end

  // FIFO write side: accept one pending word per cycle, then refresh flag and head data
  always @(negedge clk) begin
    if (wr_pend.size() > 0 && fifo_q.size() < 16) fifo_q.push_back(wr_pend.pop_front());
    if (fifo_q.size() > max_occ) max_occ = fifo_q.size();
    fifo_if.fifo_empty = (fifo_q.size() == 0);
    fifo_if.fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  // Pop strobe must never last two cycles; also tally done pulses
  always @(negedge clk) begin
    if (prev_rd) checkOutput("fifo_read_single", fifo_if.fifo_read, 0);
    prev_rd = fifo_if.fifo_read;
    if (tx_done === 1'b1) done_pulses++;
  end

  // Line monitor: decode 8N1 frames, requiring every bit to hold for CPB cycles
  initial begin : monitor
    forever begin
      @(negedge clk);
      mon_chain = (!reset && tx === 1'b0);
      while (mon_chain) begin
        frame_start_cyc.push_back(cyc);
        checkOutput("fifo_read_at_start", fifo_if.fifo_read, 1);
        mon_abort = 0;
        mon_bad = 0;
        for (int k = 0; k < 10 && !mon_abort; k++) begin
          for (int j = 0; j < CPB; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (reset) begin
              mon_abort = 1;
              break;
            end
            if (j == 0) mon_bits[k] = tx;
            else if (tx !== mon_bits[k]) mon_bad++;
            if (k == 0 && j == 1) checkOutput("fifo_read_one_cycle", fifo_if.fifo_read, 0);
            if (k == 5 && j == 0) checkOutput("busy_mid_frame", tx_busy, 1);
            if (k == 9 && j == CPB - 1) checkOutput("done_not_early", tx_done, 0);
          end
        end
        mon_chain = 0;
        if (!mon_abort) begin
          @(negedge clk);
          checkOutput("bit_width", mon_bad, 0);
          checkOutput("start_bit", mon_bits[0], 0);
          checkOutput("stop_bit", mon_bits[9], 1);
          checkOutput("done_pulse", tx_done, 1);
          if (exp_q.size() == 0) checkOutput("frame_expected", 0, 1);
          else checkOutput("frame_byte", mon_bits[8:1], exp_q.pop_front());
          frames_ok++;
          mon_chain = (!reset && tx === 1'b0);
        end
      end
    end
  end

  // Global watchdog so the run always ends
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed and randomized scenarios
  initial begin : stimulus
    int bad;
    int n;
    int pops0;
    int frames0;
    int starts0;

    // Reset state and quiet idle with an empty FIFO
    tx_enable = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_busy", tx_busy, 0);
    checkOutput("reset_done", tx_done, 0);
    checkOutput("reset_fifo_read", fifo_if.fifo_read, 0);
    #2 reset = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || fifo_if.fifo_read !== 1'b0) bad++;
    end
    checkOutput("idle_quiet_cycles_bad", bad, 0);

    // Single frame 0xA5
    pops0 = pop_count;
    applyStimulus(8'hA5);
    waitDrain(200, "drain_a5");
    checkOutput("pops_a5", pop_count - pops0, 1);
    checkOutput("busy_after_a5", tx_busy, 0);

    // Three back-to-back frames with no idle gap
    pops0 = pop_count;
    starts0 = frame_start_cyc.size();
    applyStimulus(8'h01);
    @(negedge clk);
    applyStimulus(8'hFF);
    @(negedge clk);
    applyStimulus(8'h3C);
    waitDrain(400, "drain_b2b");
    checkOutput("pops_b2b", pop_count - pops0, 3);
    checkOutput("b2b_frames", frame_start_cyc.size() - starts0, 3);
    if (frame_start_cyc.size() - starts0 == 3) begin
      checkOutput("b2b_gap1", frame_start_cyc[starts0 + 1] - frame_start_cyc[starts0], FRAME);
      checkOutput("b2b_gap2", frame_start_cyc[starts0 + 2] - frame_start_cyc[starts0 + 1], FRAME);
    end

    // tx_enable dropped mid-frame with two more words queued
    pops0 = pop_count;
    frames0 = frames_ok;
    applyStimulus(8'h55);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    waitFrameStart(50, "start_55");
    repeat (9) @(negedge clk);
    tx_enable = 1'b0;
    n = 0;
    while (frames_ok == frames0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frame_55_completed", frames_ok - frames0, 1);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    checkOutput("disabled_line_idle_bad", bad, 0);
    checkOutput("disabled_no_pop", pop_count - pops0, 1);
    tx_enable = 1'b1;
    waitDrain(300, "drain_enable");
    checkOutput("pops_enable", pop_count - pops0, 3);

    // Reset during data bit 3 of 0xC3; next word must start cleanly
    pops0 = pop_count;
    applyStimulus(8'hC3);
    applyStimulus(8'h77);
    waitFrameStart(50, "start_c3");
    repeat (17) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_tx", tx, 1);
    checkOutput("async_reset_busy", tx_busy, 0);
    checkOutput("async_reset_fifo_read", fifo_if.fifo_read, 0);
    void'(exp_q.pop_front());
    repeat (3) @(negedge clk);
    checkOutput("reset_hold_fifo_read", fifo_if.fifo_read, 0);
    #2 reset = 1'b0;
    waitDrain(200, "drain_after_reset");
    checkOutput("pops_reset", pop_count - pops0, 2);

    // Fill the FIFO to 16 words while a frame is on the line
    pops0 = pop_count;
    applyStimulus(8'($urandom));
    waitFrameStart(50, "start_fill");
    for (int i = 0; i < 16; i++) applyStimulus(8'($urandom));
    waitDrain(1200, "drain_full");
    checkOutput("fifo_reached_full", max_occ, 16);
    checkOutput("pops_full", pop_count - pops0, 17);
    checkOutput("fifo_empty_after_full", fifo_if.fifo_empty, 1);

    // Random words, random gaps, random enable toggling
    for (int i = 0; i < 12; i++) begin
      applyStimulus(8'($urandom));
      tx_enable = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(0, 60)) @(negedge clk);
    end
    tx_enable = 1'b1;
    waitDrain(2000, "drain_random");

    // Global accounting
    repeat (5) @(negedge clk);
    checkOutput("total_pops", pop_count, words_written);
    checkOutput("fifo_underflow", underflow, 0);
    checkOutput("done_pulse_count", done_pulses, frames_ok);
    checkOutput("frames_decoded", frames_ok, words_written - 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_drain.md
Name: uart_tx_fifo_drain

Overview:
Serial transmitter stage that sits directly downstream of the 16-deep word FIFO. It drains the FIFO one word at a time and shifts each word out as an 8N1 UART frame on a single TX line. The FIFO's read data is first-word fall-through: the word is valid whenever the FIFO is not empty, and a one-cycle read strobe pops it. This block latches that word, then issues the pop.

Parameters:
DATA_SIZE, 8, bits per data word; must match the FIFO word width.
CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range ≥ 2.

Ports:
clk  input  1  FPGA clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
tx_enable  input  1  when high, the block may start new frames; does not abort a frame in progress.
fifo_empty  input  1  FIFO empty flag (registered inside the FIFO).
fifo_data  input  DATA_SIZE  FIFO read data; valid while fifo_empty = 0.
fifo_read  output  1  one-cycle pop strobe to the FIFO's read input.
tx  output  1  serial line; idle level is 1.
tx_busy  output  1  high while a frame is in progress (state ≠ IDLE).
tx_done  output  1  one-cycle pulse when a stop bit completes.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE, tx = 1, tx_busy = 0, fifo_read = 0, tx_done = 0.
  - Baud counter = 0, bit index = 0, shift register = 0.
- Internal signals:
  - Baud counter width is $clog2(CLKS_PER_BIT); it counts 0 .. CLKS_PER_BIT-1.
  - "bit_end" means counter == CLKS_PER_BIT-1; the counter wraps to 0 on bit_end.
  - Bit index width is $clog2(DATA_SIZE).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx = 1.
  - At an edge where tx_enable = 1 and fifo_empty = 0: shift register <= fifo_data, fifo_read <= 1, tx <= 0, counter <= 0, state <= START.
  - Otherwise remain in IDLE.
- fifo_read:
  - High for exactly one cycle (the cycle after the latching edge), then 0.
  - Never high in two consecutive cycles.
  - Exactly one pop per frame.
- START:
  - tx = 0 for CLKS_PER_BIT cycles.
  - On bit_end: tx <= shift[0], bit index <= 0, state <= DATA.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles, sent LSB first.
  - On bit_end with index < DATA_SIZE-1: shift right by 1, tx <= next bit, index + 1.
  - On bit_end with index = DATA_SIZE-1: tx <= 1, state <= STOP.
- STOP:
  - tx = 1 for CLKS_PER_BIT cycles.
  - On bit_end: tx_done <= 1 for one cycle.
  - At that same edge, if tx_enable = 1 and fifo_empty = 0: go straight to START, latching the new word and pulsing fifo_read (no idle gap).
  - Otherwise go to IDLE.
- Frame length: exactly (DATA_SIZE+2)·CLKS_PER_BIT cycles from the tx falling edge to the end of the stop bit.
- Back-to-back throughput: one word per (DATA_SIZE+2)·CLKS_PER_BIT cycles.
- fifo_empty is sampled only in IDLE or at STOP bit_end. The FIFO's one-cycle flag latency therefore never causes a double pop.
- tx_enable deasserted mid-frame: the current frame completes normally, then the block idles.
- fifo_data is ignored outside the latching edge; changes mid-frame do not affect the shift register.
- Reset mid-frame: tx returns to 1 immediately and the frame is abandoned. The word is lost because the FIFO was already popped. No fifo_read is issued during reset or on the first edge after release unless the IDLE start condition holds.
- FIFO full or empty transitions have no effect beyond the sampling rules above.

Test Plan (CLKS_PER_BIT = 4, DATA_SIZE = 8):
1. Reset released, fifo_empty = 1 for 100 cycles -> tx = 1, tx_busy = 0, fifo_read never asserts.
2. FIFO holds 0xA5, tx_enable = 1:
   - fifo_read is high for exactly 1 cycle.
   - tx sequence, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1.
   - tx_done pulses at cycle 40; tx_busy then falls.
3. FIFO holds 0x01, 0xFF, 0x3C -> three contiguous 40-cycle frames with no idle gap, 3 fifo_read pulses each 40 cycles apart, decoded bytes 0x01, 0xFF, 0x3C.
4. tx_enable dropped at cycle 10 of a 0x55 frame with two words queued -> the 0x55 frame completes; no further fifo_read until tx_enable = 1 again, then 0x second word is sent.
5. Reset asserted in DATA bit 3 of 0xC3 -> tx = 1 and tx_busy = 0 asynchronously; after release with the FIFO non-empty, the next word starts cleanly with a full start bit.
6. FIFO written to full (16 words) while transmitting -> all 16 words are emitted in order; fifo_read count = 16; the FIFO's empty flag rises after the last pop.
